// File: rtl/rst_seq_gen.sv
// Reset sequencer: async-assert / sync-deassert reset with a hold window and optional soft reset.
// Soft reset (SOFT state, soft_rst_req, soft_rst_ack) is built only with RST_SEQ_GEN_SOFT_RST_EN.
module rst_seq_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       soft_rst_req,
  output logic       rst_out_n,
  output logic       soft_rst_ack,
  output logic [1:0] rst_cause
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);

  localparam logic [1:0] StReset = 2'b00;
  localparam logic [1:0] StHold  = 2'b01;
  localparam logic [1:0] StRun   = 2'b10;
`ifdef RST_SEQ_GEN_SOFT_RST_EN
  localparam logic [1:0] StSoft  = 2'b11;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rstn;
  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic                   rst_out_q, rst_out_d;

  // Release synchronizer: clears asynchronously, fills with ones on the clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rstn = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_GEN_SOFT_RST_EN
  logic ack_q, ack_d;
`else
  logic unused_soft_rst_req;
  assign unused_soft_rst_req = soft_rst_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
`ifdef RST_SEQ_GEN_SOFT_RST_EN
    ack_d   = 1'b0;
`endif
    case (state_q)
      StReset: begin
        if (sync_rstn) begin
          state_d = StHold;
          cnt_d   = CntLoad;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StRun;
          cause_d = 2'b01;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRun: begin
`ifdef RST_SEQ_GEN_SOFT_RST_EN
        if (soft_rst_req) begin
          state_d = StSoft;
          cnt_d   = CntLoad;
        end
`endif
      end
`ifdef RST_SEQ_GEN_SOFT_RST_EN
      StSoft: begin
        if (cnt_q == '0) begin
          state_d = StRun;
          cause_d = 2'b10;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif
      default: state_d = StReset;
    endcase
  end

  // Output is registered from the next state so it rises on the edge that enters RUN.
  assign rst_out_d = (state_d == StRun);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      cause_q   <= 2'b00;
      rst_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      rst_out_q <= rst_out_d;
    end
  end

`ifdef RST_SEQ_GEN_SOFT_RST_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign soft_rst_ack = ack_q;
`else
  assign soft_rst_ack = 1'b0;
`endif

  assign rst_out_n = rst_out_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default instance plus a HOLD_CYCLES=1, SYNC_STAGES=3 instance.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       soft_req, soft_req2;
  logic       rst_out_n, soft_ack, rst_out_n2, soft_ack2;
  logic [1:0] cause, cause2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rst_seq_gen dut (
    .clk          (clk),
    .rstn         (rstn),
    .soft_rst_req (soft_req),
    .rst_out_n    (rst_out_n),
    .soft_rst_ack (soft_ack),
    .rst_cause    (cause)
  );

  rst_seq_gen #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1)
  ) dut2 (
    .clk          (clk),
    .rstn         (rstn),
    .soft_rst_req (soft_req2),
    .rst_out_n    (rst_out_n2),
    .soft_rst_ack (soft_ack2),
    .rst_cause    (cause2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges after a release between edges; pulses soft requests into edge 4 (HOLD / RESET).
  task automatic release_seq(input string tag);
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_rst"}, {31'd0, rst_out_n}, {31'd0, i >= 19});
      check({tag, "_rst2"}, {31'd0, rst_out_n2}, {31'd0, i >= 5});
      check({tag, "_ack"}, {31'd0, soft_ack}, 32'd0);
      check({tag, "_ack2"}, {31'd0, soft_ack2}, 32'd0);
      soft_req  = (i == 3);
      soft_req2 = (i == 3);
    end
    soft_req  = 1'b0;
    soft_req2 = 1'b0;
    check({tag, "_cause"}, {30'd0, cause}, 32'd1);
    check({tag, "_cause2"}, {30'd0, cause2}, 32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    soft_req  = 1'b0;
    soft_req2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_out_reset", {31'd0, rst_out_n}, 32'd0);
    check("ack_reset", {31'd0, soft_ack}, 32'd0);
    check("cause_reset", {30'd0, cause}, 32'd0);
    check("rst_out2_reset", {31'd0, rst_out_n2}, 32'd0);
    check("cause2_reset", {30'd0, cause2}, 32'd0);

    @(negedge clk);
    rstn = 1'b1;
    release_seq("por");

`ifdef RST_SEQ_GEN_SOFT_RST_EN
    // Soft reset on both; a second request lands while the default instance is in SOFT.
    soft_req  = 1'b1;
    soft_req2 = 1'b1;
    for (int j = 0; j <= 17; j++) begin
      @(posedge clk);
      #1;
      check("soft_rst", {31'd0, rst_out_n}, {31'd0, j >= 16});
      check("soft_ack", {31'd0, soft_ack}, {31'd0, j == 16});
      if (j <= 2) begin
        check("soft_rst2", {31'd0, rst_out_n2}, {31'd0, j != 0});
        check("soft_ack2", {31'd0, soft_ack2}, {31'd0, j == 1});
      end
      soft_req  = (j == 4);
      soft_req2 = 1'b0;
    end
    check("soft_cause", {30'd0, cause}, 32'd2);
    check("soft_cause2", {30'd0, cause2}, 32'd2);

    // Held request on the short instance: alternating SOFT and ack cycles.
    soft_req2 = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk);
      #1;
      check("b2b_rst2", {31'd0, rst_out_n2}, {31'd0, (j % 2) == 1});
      check("b2b_ack2", {31'd0, soft_ack2}, {31'd0, (j % 2) == 1});
      check("b2b_rst_other", {31'd0, rst_out_n}, 32'd1);
    end
    soft_req2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`else
    soft_req  = 1'b1;
    soft_req2 = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      check("nosoft_rst", {31'd0, rst_out_n}, 32'd1);
      check("nosoft_ack", {31'd0, soft_ack}, 32'd0);
      check("nosoft_rst2", {31'd0, rst_out_n2}, 32'd1);
    end
    soft_req  = 1'b0;
    soft_req2 = 1'b0;
    check("nosoft_cause", {30'd0, cause}, 32'd1);
`endif

    // 3 ns mid-cycle glitch must reset immediately and restart the full sequence.
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("glitch_rst", {31'd0, rst_out_n}, 32'd0);
    check("glitch_rst2", {31'd0, rst_out_n2}, 32'd0);
    check("glitch_cause", {30'd0, cause}, 32'd0);
    check("glitch_ack", {31'd0, soft_ack}, 32'd0);
    #2;
    rstn = 1'b1;
    release_seq("glitch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, number of cycles the output reset is held after synchronized release (legal 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset; the only reset input.
REQ-005 SHALL have port soft_rst_req  input  1  synchronous soft-reset request, sampled on every clk rising edge.
REQ-006 SHALL have port rst_out_n  output  1  registered active-low reset driving downstream asynchronous-reset flip-flops.
REQ-007 SHALL have port soft_rst_ack  output  1  one-cycle pulse marking completion of a soft reset.
REQ-008 SHALL have port rst_cause  output  2  cause of the last reset: 00 none, 01 external rstn, 10 soft; 11 never driven.

Function
REQ-009 SHALL implement a SYNC_STAGES-deep shift chain that clears to 0 asynchronously on rstn low and shifts in 1 on each clk edge; sync_rstn is the last stage.
REQ-010 SHALL implement states RESET, HOLD, RUN, SOFT with a down-counter of width clog2(HOLD_CYCLES+1).
REQ-011 RESET: rst_out_n=0; on the first edge with sync_rstn=1, go to HOLD and load counter with HOLD_CYCLES-1.
REQ-012 HOLD: rst_out_n=0; decrement each edge; on the edge where counter is 0, go to RUN.
REQ-013 rst_out_n SHALL be registered and equal 1 only in RUN; it rises exactly SYNC_STAGES+HOLD_CYCLES+1 clk rising edges after rstn rises (19 for defaults).
REQ-014 rst_out_n SHALL fall in the same instant rstn falls, with no clk edge required (asynchronous assertion, synchronous deassertion).
REQ-015 RUN with soft_rst_req=1 on an edge: go to SOFT, load counter with HOLD_CYCLES-1, rst_out_n=0 from the next cycle.
REQ-016 SOFT: decrement each edge; on the edge where counter is 0, go to RUN and drive soft_rst_ack=1 for exactly that following cycle.
REQ-017 soft_rst_req SHALL be ignored in RESET, HOLD and SOFT; it is neither queued nor extends the hold.
REQ-018 rst_cause SHALL become 01 on the edge entering RUN from HOLD and 10 on the edge entering RUN from SOFT; it holds otherwise.
REQ-019 HOLD_CYCLES=1 SHALL give a one-cycle HOLD/SOFT state; no zero-length path exists.
REQ-020 soft_rst_req held high continuously SHALL cause back-to-back soft resets, with one RUN cycle (ack cycle) between them.

Reset
REQ-021 rstn low SHALL asynchronously force: sync chain all 0, state RESET, counter 0, rst_out_n=0, soft_rst_ack=0, rst_cause=00.
REQ-022 rstn low during HOLD or SOFT SHALL abort the sequence; the following release restarts the full SYNC_STAGES+HOLD_CYCLES+1 delay.
REQ-023 rstn glitches shorter than one clk period SHALL still fully reset the block and restart the sequence.

Configuration
REQ-024 Macro RST_SEQ_GEN_SOFT_RST_EN SHALL, when defined, compile in the SOFT state, soft_rst_req handling and soft_rst_ack generation.
REQ-025 Without RST_SEQ_GEN_SOFT_RST_EN, the ports SHALL remain, soft_rst_req SHALL be ignored, soft_rst_ack SHALL be constant 0 and rst_cause SHALL only take 00 or 01.

Verification
REQ-026 Defaults, rstn low 5 cycles then high between edges -> rst_out_n=0 through edge 18, 1 after edge 19, rst_cause=01.
REQ-027 RUN, rstn pulsed low 3 ns mid-cycle -> rst_out_n low immediately, high again 19 edges after the pulse ends, soft_rst_ack stays 0.
REQ-028 Macro defined, RUN, soft_rst_req high one cycle -> rst_out_n low next cycle for 16 cycles, then high with soft_rst_ack=1 one cycle, rst_cause=10.
REQ-029 Macro defined, soft_rst_req pulsed during HOLD and during SOFT -> no effect on timing, one ack only.
REQ-030 HOLD_CYCLES=1, SYNC_STAGES=3 -> rst_out_n rises 5 edges after rstn release; soft reset gives exactly one low cycle.
REQ-031 Macro undefined, soft_rst_req high in RUN for 20 cycles -> rst_out_n stays 1, soft_rst_ack 0, rst_cause 01.
